// File: rtl/framebuffer_write_arbiter.sv
// Framebuffer write arbiter: round-robin sharing of the BRAM write port among
// the ray-marcher cores, plus double-buffer bank swapping on vsync once a
// frame has been fully accepted.
module framebuffer_write_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int DISPLAY_WIDTH  = 160,
    parameter int DISPLAY_HEIGHT = 120,
    parameter int ADDR_BITS      = 15
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NUM_CORES-1:0]           core_valid_in,
    input  logic [NUM_CORES*ADDR_BITS-1:0] core_addr_in,
    input  logic [NUM_CORES*4-1:0]         core_data_in,
    output logic [NUM_CORES-1:0]           core_ready_out,
    output logic                           frame_start_out,
    input  logic                           vsync_in,
    output logic                           wr_en_out,
    output logic [ADDR_BITS:0]             wr_addr_out,
    output logic [3:0]                     wr_data_out,
    output logic                           front_bank_out,
    output logic                           addr_err_out
);

    localparam int PIXELS   = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam int CNT_BITS = $clog2(PIXELS + 1);
    localparam int PTR_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        ST_START,
        ST_RENDER,
        ST_WAIT_VSYNC
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_BITS-1:0]    ptr_q, ptr_d;
    logic [CNT_BITS-1:0]    pix_cnt_q, pix_cnt_d;
    logic                   front_q, front_d;
    logic                   vsync_q;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_BITS:0]     wr_addr_q, wr_addr_d;
    logic [3:0]             wr_data_q, wr_data_d;
    logic                   err_q, err_d;

    logic [ADDR_BITS-1:0]   addr_arr [NUM_CORES];
    logic [3:0]             data_arr [NUM_CORES];
    logic                   grant_found;
    logic [PTR_BITS-1:0]    grant_idx;
    logic                   transfer;
    logic [ADDR_BITS-1:0]   sel_addr;
    logic [3:0]             sel_data;
    logic                   addr_in_range;
    logic                   frame_start;

    // Unpack the flat per-core address/data buses into indexable arrays
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            addr_arr[i] = core_addr_in[i*ADDR_BITS +: ADDR_BITS];
            data_arr[i] = core_data_in[i*4 +: 4];
        end
    end

    // Round-robin search: first valid core at or after the pointer wins
    always_comb begin
        int                  cand;
        logic [PTR_BITS-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = 0; off < NUM_CORES; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NUM_CORES) begin
                cand = cand - NUM_CORES;
            end
            cand_idx = PTR_BITS'(cand);
            if (!grant_found && core_valid_in[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign transfer       = (state_q == ST_RENDER) && grant_found;
    assign core_ready_out = transfer ? (NUM_CORES'(1) << grant_idx) : '0;
    assign sel_addr       = addr_arr[grant_idx];
    assign sel_data       = data_arr[grant_idx];
    assign addr_in_range  = ({1'b0, sel_addr} < (ADDR_BITS+1)'(PIXELS));

    // Next-state logic for the frame FSM, arbitration pointer and write pipeline
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        pix_cnt_d   = pix_cnt_q;
        front_d     = front_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;
        frame_start = 1'b0;
        case (state_q)
            ST_START: begin
                frame_start = 1'b1;
                pix_cnt_d   = '0;
                state_d     = ST_RENDER;
            end
            ST_RENDER: begin
                if (transfer) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    ptr_d     = (grant_idx == PTR_BITS'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
                    wr_addr_d = {~front_q, sel_addr};
                    wr_data_d = sel_data;
                    if (addr_in_range) begin
                        wr_en_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (pix_cnt_q == CNT_BITS'(PIXELS - 1)) begin
                        state_d = ST_WAIT_VSYNC;
                    end
                end
            end
            ST_WAIT_VSYNC: begin
                if (vsync_in && !vsync_q) begin
                    front_d = ~front_q;
                    state_d = ST_START;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // State registers; reset abandons the frame and drops any pending write
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_START;
            ptr_q     <= '0;
            pix_cnt_q <= '0;
            front_q   <= 1'b0;
            vsync_q   <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pix_cnt_q <= pix_cnt_d;
            front_q   <= front_d;
            vsync_q   <= vsync_in;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign frame_start_out = frame_start && !rst_in;
    assign wr_en_out       = wr_en_q;
    assign wr_addr_out     = wr_addr_q;
    assign wr_data_out     = wr_data_q;
    assign front_bank_out  = front_q;
    assign addr_err_out    = err_q;

endmodule
